// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable data width, parity and stop bits, 3-sample majority
// voting, per-frame error/break status and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = PAYLOAD_BITS + 3;

  localparam logic [CW-1:0] CYC_S0    = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CYC_S1    = CW'(CPB / 2);
  localparam logic [CW-1:0] CYC_VOTE  = CW'(CPB / 2 + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_of(input logic [PAYLOAD_BITS-1:0] d);
    return ^d;
  endfunction

  logic                    meta_r, sync_r;
  state_t                  state_r, state_next_s;
  logic [CW-1:0]           cyc_r;
  logic [BW-1:0]           bit_cnt_r;
  logic [1:0]              samp_r;
  logic [PAYLOAD_BITS-1:0] shift_r;
  logic                    pbit_r, ferr_r, zero_r;
  logic                    pend_valid_r;
  logic [EW-1:0]           pend_r;

  logic vote_s, at_vote_s, at_last_s, done_s, brk_s, ferr_s, perr_s;

  logic [EW-1:0]           mem_r [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [LW-1:0]           level_r, level_next_s;
  logic [EW-1:0]           head_r, head_next_s;
  logic                    valid_r, ovr_r;
  logic                    pop_s, full_s, wr_en_s, drop_s;

  // Two-flop synchroniser, frozen while reception is disabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else if (uart_rx_en) begin
      meta_r <= uart_rxd;
      sync_r <= meta_r;
    end
  end

  // Receive FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and per-frame result decode.
  always_comb begin
    state_next_s = state_r;
    done_s       = 1'b0;
    vote_s       = maj3(samp_r[0], samp_r[1], sync_r);
    at_vote_s    = (cyc_r == CYC_VOTE);
    at_last_s    = (cyc_r == CYC_LAST);
    brk_s        = zero_r & ~vote_s;
    ferr_s       = ferr_r | ~vote_s;
    if (PARITY != 0) begin
      perr_s = (parity_of(shift_r) ^ pbit_r) != PAR_ODD;
    end else begin
      perr_s = 1'b0;
    end
    if (!uart_rx_en) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!sync_r) state_next_s = S_START;
          else         state_next_s = S_IDLE;
        end
        S_START: begin
          if (at_vote_s && vote_s) state_next_s = S_IDLE;
          else if (at_last_s)      state_next_s = S_DATA;
          else                     state_next_s = S_START;
        end
        S_DATA: begin
          if (at_last_s && (bit_cnt_r == DATA_LAST)) begin
            if (PARITY != 0) state_next_s = S_PARITY;
            else             state_next_s = S_STOP;
          end else begin
            state_next_s = S_DATA;
          end
        end
        S_PARITY: begin
          if (at_last_s) state_next_s = S_STOP;
          else           state_next_s = S_PARITY;
        end
        S_STOP: begin
          // Leave mid-bit on the last stop vote so the next start edge is caught early.
          if (at_vote_s && (bit_cnt_r == STOP_LAST)) begin
            done_s = 1'b1;
            if (brk_s) state_next_s = S_BRK_WAIT;
            else       state_next_s = S_IDLE;
          end else begin
            state_next_s = S_STOP;
          end
        end
        S_BRK_WAIT: begin
          if (sync_r) state_next_s = S_IDLE;
          else        state_next_s = S_BRK_WAIT;
        end
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // Bit timing, sampling, shift register and per-frame status accumulation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cyc_r        <= {CW{1'b0}};
      bit_cnt_r    <= {BW{1'b0}};
      samp_r       <= 2'b11;
      shift_r      <= {PAYLOAD_BITS{1'b0}};
      pbit_r       <= 1'b0;
      ferr_r       <= 1'b0;
      zero_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_r       <= {EW{1'b0}};
    end else begin
      if (state_r == S_IDLE || state_r == S_BRK_WAIT || !uart_rx_en || at_last_s) begin
        cyc_r <= {CW{1'b0}};
      end else begin
        cyc_r <= cyc_r + CW'(1);
      end
      if (cyc_r == CYC_S0) samp_r[0] <= sync_r;
      if (cyc_r == CYC_S1) samp_r[1] <= sync_r;

      if (state_next_s != state_r) begin
        bit_cnt_r <= {BW{1'b0}};
      end else if (at_last_s && (state_r == S_DATA || state_r == S_STOP)) begin
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end

      if (state_r == S_DATA && at_vote_s) begin
        shift_r <= {vote_s, shift_r[PAYLOAD_BITS-1:1]};
      end
      if (state_r == S_START) begin
        pbit_r <= 1'b0;
        ferr_r <= 1'b0;
        zero_r <= 1'b1;
      end else begin
        if (state_r == S_PARITY && at_vote_s) pbit_r <= vote_s;
        if (state_r == S_STOP && at_vote_s && !vote_s) ferr_r <= 1'b1;
        if (at_vote_s && vote_s &&
            (state_r == S_DATA || state_r == S_PARITY || state_r == S_STOP)) begin
          zero_r <= 1'b0;
        end
      end

      pend_valid_r <= done_s;
      if (done_s) pend_r <= {brk_s, ferr_s, perr_s, shift_r};
    end
  end

  // FIFO control: push/pop decisions and next head with write-through bypass.
  always_comb begin
    pop_s   = valid_r & rx_ready;
    full_s  = (level_r == DEPTH_L);
    wr_en_s = pend_valid_r & (~full_s | pop_s);
    drop_s  = pend_valid_r & full_s & ~pop_s;
    if (pop_s) rd_next_s = rd_ptr_r + AW'(1);
    else       rd_next_s = rd_ptr_r;
    if (wr_en_s && !pop_s)      level_next_s = level_r + LW'(1);
    else if (pop_s && !wr_en_s) level_next_s = level_r - LW'(1);
    else                        level_next_s = level_r;
    if (level_next_s == {LW{1'b0}})                 head_next_s = {EW{1'b0}};
    else if (wr_en_s && (wr_ptr_r == rd_next_s))    head_next_s = pend_r;
    else                                            head_next_s = mem_r[rd_next_s];
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= pend_r;
  end

  // FIFO pointers, registered head/level/valid and sticky overrun.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      head_r   <= {EW{1'b0}};
      valid_r  <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      rd_ptr_r <= rd_next_s;
      level_r  <= level_next_s;
      head_r   <= head_next_s;
      valid_r  <= (level_next_s != {LW{1'b0}});
      if (drop_s)           ovr_r <= 1'b1;
      else if (overrun_clr) ovr_r <= 1'b0;
    end
  end

  assign rx_data       = head_r[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head_r[EW-3];
  assign rx_frame_err  = head_r[EW-2];
  assign rx_break      = head_r[EW-1];
  assign rx_valid      = valid_r;
  assign rx_overrun    = ovr_r;
  assign fifo_level    = level_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three configurations (8N1, 8E1, 8O2) at CPB=16.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [2:0] rxd, en, rdy, oclr;
  logic [7:0] o_data [3];
  logic [2:0] o_perr, o_ferr, o_brk, o_valid, o_ovr;
  logic [2:0] o_level [3];

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]), .uart_rx_en(en[0]),
    .rx_data(o_data[0]), .rx_parity_err(o_perr[0]), .rx_frame_err(o_ferr[0]),
    .rx_break(o_brk[0]), .rx_valid(o_valid[0]), .rx_ready(rdy[0]),
    .rx_overrun(o_ovr[0]), .overrun_clr(oclr[0]), .fifo_level(o_level[0]));

  uart_rx_fifo #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]), .uart_rx_en(en[1]),
    .rx_data(o_data[1]), .rx_parity_err(o_perr[1]), .rx_frame_err(o_ferr[1]),
    .rx_break(o_brk[1]), .rx_valid(o_valid[1]), .rx_ready(rdy[1]),
    .rx_overrun(o_ovr[1]), .overrun_clr(oclr[1]), .fifo_level(o_level[1]));

  uart_rx_fifo #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd[2]), .uart_rx_en(en[2]),
    .rx_data(o_data[2]), .rx_parity_err(o_perr[2]), .rx_frame_err(o_ferr[2]),
    .rx_break(o_brk[2]), .rx_valid(o_valid[2]), .rx_ready(rdy[2]),
    .rx_overrun(o_ovr[2]), .overrun_clr(oclr[2]), .fifo_level(o_level[2]));

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       p;
    logic [1:0] st;
    logic [7:0] xd;
    logic       xp;
    logic       xf;
    logic       xb;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input int sel, input logic [31:0] v, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      rxd[sel] = v[i];
      if (glitch && i >= 1 && i <= 8) begin
        repeat (8) @(negedge clk);
        rxd[sel] = ~v[i];
        @(negedge clk);
        rxd[sel] = v[i];
        repeat (7) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                            input logic [1:0] st, input bit glitch);
    logic [31:0] v;
    int n;
    v = 32'hFFFF_FFFF;
    v[0] = 1'b0;
    v[8:1] = d;
    n = 9;
    if (sel > 0) begin
      v[n] = p;
      n++;
    end
    v[n] = st[0];
    n++;
    if (sel == 2) begin
      v[n] = st[1];
      n++;
    end
    send_bits(sel, v, n, glitch);
    rxd[sel] = 1'b1;
  endtask

  task automatic pop(input int sel);
    rdy[sel] = 1'b1;
    @(negedge clk);
    rdy[sel] = 1'b0;
  endtask

  initial begin
    int k;
    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h37, 1'b1, 2'b11, 8'h37, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h37, 1'b0, 2'b11, 8'h37, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2, 8'h5A, 1'b1, 2'b01, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{2, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{2, 8'hFF, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{2, 8'h00, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1};

    resetn = 1'b0;
    rxd    = 3'b111;
    en     = 3'b111;
    rdy    = 3'b000;
    oclr   = 3'b000;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_level", 32'(o_level[s]), 32'd0);
      chk("reset_valid", 32'(o_valid[s]), 32'd0);
      chk("reset_ovr",   32'(o_ovr[s]),   32'd0);
      chk("reset_data",  32'(o_data[s]),  32'd0);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with rx_ready held: a one-cycle valid pulse
    rdy[0] = 1'b1;
    send_bits(0, 32'h0000_014A, 9, 1'b0);
    rxd[0] = 1'b1;
    k = 0;
    while (!o_valid[0] && k < 48) begin
      @(negedge clk);
      k++;
    end
    chk("pulse_valid", 32'(o_valid[0]), 32'd1);
    chk("pulse_data",  32'(o_data[0]),  32'hA5);
    chk("pulse_perr",  32'(o_perr[0]),  32'd0);
    chk("pulse_ferr",  32'(o_ferr[0]),  32'd0);
    chk("pulse_brk",   32'(o_brk[0]),   32'd0);
    @(negedge clk);
    chk("pulse_drop",  32'(o_valid[0]), 32'd0);
    chk("pulse_level", 32'(o_level[0]), 32'd0);
    rdy[0] = 1'b0;
    repeat (32) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].sel, tbl[i].d, tbl[i].p, tbl[i].st, 1'b0);
      repeat (32) @(negedge clk);
      chk($sformatf("v%0d_level", i), 32'(o_level[tbl[i].sel]), 32'd1);
      chk($sformatf("v%0d_data", i),  32'(o_data[tbl[i].sel]),  32'(tbl[i].xd));
      chk($sformatf("v%0d_perr", i),  32'(o_perr[tbl[i].sel]),  32'(tbl[i].xp));
      chk($sformatf("v%0d_ferr", i),  32'(o_ferr[tbl[i].sel]),  32'(tbl[i].xf));
      chk($sformatf("v%0d_brk", i),   32'(o_brk[tbl[i].sel]),   32'(tbl[i].xb));
      pop(tbl[i].sel);
      chk($sformatf("v%0d_popped", i), 32'(o_level[tbl[i].sel]), 32'd0);
    end

    // line held low for three frame times: exactly one break entry
    rxd[0] = 1'b0;
    repeat (480) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_level", 32'(o_level[0]), 32'd1);
    chk("brk_flag",  32'(o_brk[0]),   32'd1);
    chk("brk_ferr",  32'(o_ferr[0]),  32'd1);
    chk("brk_data",  32'(o_data[0]),  32'd0);
    pop(0);

    // 4-cycle start glitch
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (64) @(negedge clk);
    chk("glitch_level", 32'(o_level[0]), 32'd0);
    chk("glitch_valid", 32'(o_valid[0]), 32'd0);

    // single-cycle pulses inside every data bit
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1);
    repeat (32) @(negedge clk);
    chk("spike_level", 32'(o_level[0]), 32'd1);
    chk("spike_data",  32'(o_data[0]),  32'hA5);
    chk("spike_ferr",  32'(o_ferr[0]),  32'd0);
    pop(0);

    // overrun: five back-to-back frames into a 4-deep FIFO
    for (int b = 1; b <= 5; b++) begin
      send_frame(0, 8'(b), 1'b0, 2'b11, 1'b0);
    end
    repeat (32) @(negedge clk);
    chk("ovr_level", 32'(o_level[0]), 32'd4);
    chk("ovr_flag",  32'(o_ovr[0]),   32'd1);
    for (int b = 1; b <= 4; b++) begin
      chk($sformatf("drain%0d", b), 32'(o_data[0]), 32'(b));
      pop(0);
    end
    chk("drain_level", 32'(o_level[0]), 32'd0);
    chk("drain_valid", 32'(o_valid[0]), 32'd0);
    chk("ovr_sticky",  32'(o_ovr[0]),   32'd1);
    oclr[0] = 1'b1;
    @(negedge clk);
    oclr[0] = 1'b0;
    chk("ovr_clr", 32'(o_ovr[0]), 32'd0);

    // reset in the middle of a frame with one entry already queued
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
    repeat (32) @(negedge clk);
    chk("pre_rst_level", 32'(o_level[0]), 32'd1);
    send_bits(0, 32'h0000_0016, 5, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rxd[0] = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_level", 32'(o_level[0]), 32'd0);
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_data",  32'(o_data[0]),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
